segment_button_ctrl: RTL

- Input front-end and arbiter for the 7-segment driver. Conditions two raw push-buttons, btn_next and btn_mode: 2-FF synchroniser, debounce FSM, and auto-repeat for btn_next only.
- Produces single-cycle next_segment_re / change_mode_re pulses.
- Guarantees the two pulses never fire in the same cycle; the segment driver is fed by exactly one event per cycle.

---
 rtl/segment_button_ctrl_pkg.sv | 19 +
 rtl/segment_button_ctrl_button_debounce.sv | 120 ++++++++++++
 rtl/segment_button_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/segment_button_ctrl_pkg.sv
// Shared types for the segment driver button front-end.
//   btn_state_e : per-button debounce FSM state (fixed 2-bit encoding)
//   is_held()   : true while the debounced level of a button is high
package segment_button_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StPressed     = 2'd2,
        StReleaseWait = 2'd3
    } btn_state_e;

    // A button counts as held both while stably pressed and while a release
    // is still being qualified, so short low glitches never drop the level.
    function automatic logic is_held(input btn_state_e s);
        return (s == StPressed) || (s == StReleaseWait);
    endfunction

endpackage

// File: rtl/segment_button_ctrl_button_debounce.sv
// Conditions one raw push-button: 2-FF synchroniser, debounce FSM and an
// optional auto-repeat generator.
// Ports:
//   clk          : system clock
//   async_nreset : asynchronous active-low reset
//   btn_raw      : raw asynchronous button, active high
//   evt          : one-cycle pulse per accepted press or auto-repeat
//   held         : debounced button level
module button_debounce
    import segment_button_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 500000,
    parameter bit          REPEAT_EN           = 1'b0,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000,
    parameter int unsigned CNT_W               = 25
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic btn_raw,
    output logic evt,
    output logic held
);

    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;  // first repeat already emitted
    logic             evt_q, evt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            evt_q       <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            evt_q       <= evt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        evt_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sync2_q) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!sync2_q) begin
                    state_d = StIdle;
                end else if (cnt_q == DebLast) begin
                    state_d     = StPressed;
                    evt_d       = 1'b1;
                    rep_cnt_d   = '0;
                    rep_armed_d = 1'b0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            StPressed: begin
                // The repeat timer ticks on every cycle spent here, including
                // the cycle that leaves for release qualification.
                if (REPEAT_EN) begin
                    if (rep_cnt_q == (rep_armed_q ? RateLast : DelayLast)) begin
                        evt_d       = 1'b1;
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b1;
                    end else begin
                        rep_cnt_d = sat_inc(rep_cnt_q);
                    end
                end
                if (!sync2_q) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                // Repeat timer is frozen; a bounce back high resumes it as-is.
                if (sync2_q) begin
                    state_d = StPressed;
                end else if (cnt_q == DebLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign evt  = evt_q;
    assign held = is_held(state_q);

endmodule

// File: rtl/segment_button_ctrl.sv
// Button front-end and arbiter for the 7-segment driver. Debounces btn_next
// (with auto-repeat) and btn_mode, and serialises their events so that at
// most one output pulse fires per cycle.
// Ports:
//   clk             : system clock
//   async_nreset    : asynchronous active-low reset
//   btn_next        : raw button, active high (auto-repeats)
//   btn_mode        : raw button, active high
//   next_segment_re : one-cycle pulse, step segment
//   change_mode_re  : one-cycle pulse, advance mode
//   next_held       : debounced level of btn_next
module segment_button_ctrl
    import segment_button_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 500000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000,
    parameter int unsigned CNT_W               = 25
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic btn_next,
    input  logic btn_mode,
    output logic next_segment_re,
    output logic change_mode_re,
    output logic next_held
);

    logic next_evt, mode_evt;
    logic unused_mode_held;
    logic next_pend_q, next_pend_d;
    logic mode_pend_q, mode_pend_d;

    button_debounce #(
        .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
        .REPEAT_EN          (1'b1),
        .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
        .CNT_W              (CNT_W)
    ) u_next (
        .clk         (clk),
        .async_nreset(async_nreset),
        .btn_raw     (btn_next),
        .evt         (next_evt),
        .held        (next_held)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
        .REPEAT_EN          (1'b0),
        .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
        .CNT_W              (CNT_W)
    ) u_mode (
        .clk         (clk),
        .async_nreset(async_nreset),
        .btn_raw     (btn_mode),
        .evt         (mode_evt),
        .held        (unused_mode_held)
    );

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            next_pend_q <= 1'b0;
            mode_pend_q <= 1'b0;
        end else begin
            next_pend_q <= next_pend_d;
            mode_pend_q <= mode_pend_d;
        end
    end

    // Priority: deferred next > deferred/new mode > new next. The branches
    // guarantee the two pending flags are never set together, so arrival
    // order is preserved. A new event colliding with its own pending flag
    // merges into it.
    always_comb begin
        next_pend_d     = 1'b0;
        mode_pend_d     = 1'b0;
        next_segment_re = 1'b0;
        change_mode_re  = 1'b0;
        if (next_pend_q) begin
            next_segment_re = 1'b1;
            mode_pend_d     = mode_evt;
        end else if (mode_pend_q || mode_evt) begin
            change_mode_re = 1'b1;
            next_pend_d    = next_evt;
        end else begin
            next_segment_re = next_evt;
        end
    end

endmodule
